// File: rtl/bash_line_exec.sv
// Command-execution stage behind the bash terminal: reads one line, decodes echo/unknown
// (plus "help" when BASH_HELP_CMD_EN is defined), streams the response, then handshakes solved.
module bash_line_exec #(
    parameter int BUFFER_LEN = 128,
    parameter int LEN_W      = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             term_ready,
    input  logic [LEN_W-1:0] term_len,
    input  logic [7:0]       term_char,
    output logic             term_next,
    output logic             resp_ready,
    output logic [7:0]       resp_char,
    input  logic             resp_next,
    output logic             solved,
    input  logic             solved_ack,
    output logic             busy
);
    localparam int CNT_W = $clog2(BUFFER_LEN) + 1;
    localparam int IDX_W = $clog2(BUFFER_LEN);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RECV     = 3'd1;
    localparam logic [2:0] S_DRAIN    = 3'd2;
    localparam logic [2:0] S_PARSE    = 3'd3;
    localparam logic [2:0] S_SEND     = 3'd4;
    localparam logic [2:0] S_SOLVE    = 3'd5;
    localparam logic [2:0] S_WAIT_ACK = 3'd6;

    localparam logic [1:0] C_EMPTY = 2'd0;
    localparam logic [1:0] C_ECHO  = 2'd1;
    localparam logic [1:0] C_NF    = 2'd2;

    localparam int               NF_LEN = 17;
    localparam logic [8*NF_LEN-1:0] NF_STR = "command not found";
`ifdef BASH_HELP_CMD_EN
    localparam logic [1:0]       C_HELP   = 2'd3;
    localparam int               HELP_LEN = 15;
    localparam logic [8*HELP_LEN-1:0] HELP_STR = "cmds: echo help";
`endif

    logic [2:0]       state;
    logic [1:0]       cmd;
    logic [CNT_W-1:0] eff_len, rd_cnt, wr_cnt, src_len;
    logic [7:0]       line_buf [BUFFER_LEN];

    logic             is_echo;
    logic [CNT_W-1:0] echo_sum;
    logic [7:0]       resp_ch;
    logic [8*NF_LEN-1:0] nf_sh;

    assign term_next  = (state == S_RECV) && (rd_cnt < eff_len);
    assign resp_ready = (state == S_SEND);
    assign resp_char  = (state == S_SEND) ? resp_ch : 8'h00;
    assign solved     = (state == S_SOLVE);
    assign busy       = (state != S_IDLE);

    // Length gate first: buffer bytes past eff_len are stale from an earlier line.
    assign is_echo = (eff_len >= CNT_W'(4)) &&
                     (line_buf[0] == "e") && (line_buf[1] == "c") &&
                     (line_buf[2] == "h") && (line_buf[3] == "o") &&
                     ((eff_len == CNT_W'(4)) || (line_buf[4] == 8'h20));

`ifdef BASH_HELP_CMD_EN
    logic                    is_help;
    logic [8*HELP_LEN-1:0]   help_sh;
    assign is_help = (eff_len == CNT_W'(4)) &&
                     (line_buf[0] == "h") && (line_buf[1] == "e") &&
                     (line_buf[2] == "l") && (line_buf[3] == "p");
    assign help_sh = HELP_STR << (8 * wr_cnt);
`endif

    assign echo_sum = wr_cnt + CNT_W'(5);
    assign nf_sh    = NF_STR << (8 * wr_cnt);

    // Character at wr_cnt of the selected source; 0 once the source is exhausted.
    always_comb begin
        resp_ch = 8'h00;
        if (wr_cnt != src_len) begin
            case (cmd)
                C_ECHO:  resp_ch = line_buf[echo_sum[IDX_W-1:0]];
                C_NF:    resp_ch = nf_sh[8*NF_LEN-1 -: 8];
`ifdef BASH_HELP_CMD_EN
                C_HELP:  resp_ch = help_sh[8*HELP_LEN-1 -: 8];
`endif
                default: resp_ch = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (term_next)
            line_buf[rd_cnt[IDX_W-1:0]] <= term_char;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cmd     <= C_EMPTY;
            eff_len <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            src_len <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (term_ready) begin
                        rd_cnt <= '0;
                        if (term_len > LEN_W'(BUFFER_LEN))
                            eff_len <= CNT_W'(BUFFER_LEN);
                        else
                            eff_len <= term_len[CNT_W-1:0];
                        state <= (term_len == '0) ? S_DRAIN : S_RECV;
                    end
                end
                S_RECV: begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_cnt == eff_len - 1'b1)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!term_ready)
                        state <= S_PARSE;
                end
                S_PARSE: begin
                    wr_cnt <= '0;
                    if (eff_len == '0) begin
                        cmd     <= C_EMPTY;
                        src_len <= '0;
                        state   <= S_SOLVE;
                    end else if (is_echo) begin
                        cmd     <= C_ECHO;
                        src_len <= (eff_len > CNT_W'(5)) ? eff_len - CNT_W'(5) : '0;
                        state   <= S_SEND;
`ifdef BASH_HELP_CMD_EN
                    end else if (is_help) begin
                        cmd     <= C_HELP;
                        src_len <= CNT_W'(HELP_LEN);
                        state   <= S_SEND;
`endif
                    end else begin
                        cmd     <= C_NF;
                        src_len <= CNT_W'(NF_LEN);
                        state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (resp_next) begin
                        if (resp_ch == 8'h00)
                            state <= S_SOLVE;
                        else
                            wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                S_SOLVE:    state <= solved_ack ? S_IDLE : S_WAIT_ACK;
                S_WAIT_ACK: if (solved_ack) state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bash_line_exec.sv
// Directed bench for bash_line_exec: plays the terminal on both handshakes and
// checks line intake, responses, truncation, stalls, reset abort and solved/ack.
module tb_bash_line_exec;
    typedef logic [7:0] bq_t[$];

    logic        clk = 0;
    logic        rst;
    logic        term_ready;
    logic [12:0] term_len;
    logic [7:0]  term_char;
    logic        term_next;
    logic        resp_ready;
    logic [7:0]  resp_char;
    logic        resp_next;
    logic        solved;
    logic        solved_ack;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bash_line_exec #(.BUFFER_LEN(128), .LEN_W(13)) dut (
        .clk(clk), .rst(rst),
        .term_ready(term_ready), .term_len(term_len), .term_char(term_char), .term_next(term_next),
        .resp_ready(resp_ready), .resp_char(resp_char), .resp_next(resp_next),
        .solved(solved), .solved_ack(solved_ack), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bq_t s2q(input string s);
        bq_t q;
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Terminal side of the line read: present chars, advance on term_next.
    task automatic feed(input bq_t s, input int len, output int pulses);
        pulses = 0;
        @(negedge clk);
        term_ready = 1; term_len = 13'(len);
        term_char  = (s.size() > 0) ? s[0] : 8'h00;
        @(negedge clk);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!term_next) break;
            pulses++;
            @(posedge clk);
            #1 term_char = (pulses < s.size()) ? s[pulses] : 8'h00;
            @(negedge clk);
        end
        term_ready = 0; term_char = 8'h00;
    endtask

    // Terminal side of the response: take bytes with dly stall cycles each.
    task automatic get_resp(input int dly, input int max_bytes, output bq_t q,
                            output bit got_solved, output int unstable);
        logic [7:0] c;
        q = {}; got_solved = 0; unstable = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (q.size() >= max_bytes) break;
            @(negedge clk);
            if (solved) begin got_solved = 1; break; end
            if (resp_ready) begin
                c = resp_char;
                for (int d = 0; d < dly; d++) begin
                    @(negedge clk);
                    if (resp_char !== c || resp_ready !== 1'b1) unstable++;
                end
                resp_next = 1;
                q.push_back(c);
                @(negedge clk);
                resp_next = 0;
                if (solved) begin got_solved = 1; break; end
            end
        end
    endtask

    task automatic check_resp(input string tag, input bq_t got, input bq_t exp);
        chk({tag, "_nbytes"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    // Entered at the negedge where solved was seen.
    task automatic finish_cmd(input string tag, input bit early_ack);
        chk({tag, "_rdy_at_solved"}, resp_ready, 0);
        if (early_ack) begin
            solved_ack = 1;
            @(negedge clk);
            solved_ack = 0;
            chk({tag, "_idle_after_early_ack"}, busy, 0);
        end else begin
            @(negedge clk);
            chk({tag, "_solved_one_cycle"}, solved, 0);
            term_ready = 1;
            @(negedge clk);
            chk({tag, "_ignore_ready_wait"}, term_next, 0);
            chk({tag, "_busy_wait"}, busy, 1);
            term_ready = 0; solved_ack = 1;
            @(negedge clk);
            solved_ack = 0;
            chk({tag, "_idle_after_ack"}, busy, 0);
        end
    endtask

    initial begin
        int   pulses, unstable, nsolved;
        bit   gs;
        bq_t  q, exp, line;

        rst = 1; term_ready = 0; term_len = '0; term_char = '0;
        resp_next = 0; solved_ack = 0;
        repeat (3) @(negedge clk);
        chk("rst_term_next", term_next, 0);
        chk("rst_resp_ready", resp_ready, 0);
        chk("rst_resp_char", resp_char, 0);
        chk("rst_solved", solved, 0);
        chk("rst_busy", busy, 0);
        rst = 0;
        @(negedge clk);

        // empty line
        feed(s2q(""), 0, pulses);
        chk("empty_pulses", pulses, 0);
        get_resp(0, 100, q, gs, unstable);
        chk("empty_solved", gs, 1);
        chk("empty_nbytes", q.size(), 0);
        finish_cmd("empty", 0);

        // echo hi
        feed(s2q("echo hi"), 7, pulses);
        chk("echohi_pulses", pulses, 7);
        get_resp(0, 100, q, gs, unstable);
        chk("echohi_solved", gs, 1);
        exp = s2q("hi"); exp.push_back(8'h00);
        check_resp("echohi", q, exp);
        finish_cmd("echohi", 0);

        // unknown command, acked in the solved cycle
        feed(s2q("ls"), 2, pulses);
        chk("ls_pulses", pulses, 2);
        get_resp(0, 100, q, gs, unstable);
        chk("ls_solved", gs, 1);
        exp = s2q("command not found"); exp.push_back(8'h00);
        check_resp("ls", q, exp);
        finish_cmd("ls", 1);

        // bare "echo": empty source
        feed(s2q("echo"), 4, pulses);
        get_resp(0, 100, q, gs, unstable);
        chk("echo4_solved", gs, 1);
        exp = {}; exp.push_back(8'h00);
        check_resp("echo4", q, exp);
        finish_cmd("echo4", 0);

        // stalled consumer
        feed(s2q("echo abc"), 8, pulses);
        get_resp(5, 100, q, gs, unstable);
        chk("stall_solved", gs, 1);
        chk("stall_unstable", unstable, 0);
        exp = s2q("abc"); exp.push_back(8'h00);
        check_resp("stall", q, exp);
        finish_cmd("stall", 0);

        // overlong line truncated to 128
        line = s2q("echo ");
        for (int i = 5; i < 200; i++) line.push_back(8'(8'h41 + (i % 26)));
        feed(line, 200, pulses);
        chk("trunc_pulses", pulses, 128);
        get_resp(0, 200, q, gs, unstable);
        chk("trunc_solved", gs, 1);
        exp = {};
        for (int i = 5; i < 128; i++) exp.push_back(line[i]);
        exp.push_back(8'h00);
        check_resp("trunc", q, exp);
        finish_cmd("trunc", 0);

        // reset in the middle of a response
        feed(s2q("echo hello"), 10, pulses);
        get_resp(0, 3, q, gs, unstable);
        chk("abort_nbytes", q.size(), 3);
        rst = 1;
        @(negedge clk);
        chk("abort_resp_ready", resp_ready, 0);
        chk("abort_busy", busy, 0);
        rst = 0;
        nsolved = 0;
        repeat (6) begin @(negedge clk); if (solved) nsolved++; end
        chk("abort_no_solved", nsolved, 0);

        feed(s2q("echo a"), 6, pulses);
        chk("post_pulses", pulses, 6);
        get_resp(0, 100, q, gs, unstable);
        chk("post_solved", gs, 1);
        exp = s2q("a"); exp.push_back(8'h00);
        check_resp("post", q, exp);
        finish_cmd("post", 0);

        // help: built-in when enabled, otherwise unknown
        feed(s2q("help"), 4, pulses);
        get_resp(0, 100, q, gs, unstable);
        chk("help_solved", gs, 1);
`ifdef BASH_HELP_CMD_EN
        exp = s2q("cmds: echo help");
`else
        exp = s2q("command not found");
`endif
        exp.push_back(8'h00);
        check_resp("help", q, exp);
        finish_cmd("help", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bash_line_exec.md
Name: bash_line_exec

Overview:
- Command-execution stage directly downstream of the bash terminal video-memory block.
- Pulls one entered line from the terminal over its char-by-char output handshake and stores it in a local buffer.
- Decodes a small built-in command set, then streams a response line back over the terminal's input handshake.
- Finishes each command with a solved pulse and waits for the terminal's acknowledge before accepting the next line.

Parameters:
BUFFER_LEN, 128, max stored characters per line; longer lines are truncated.
LEN_W, 13, width of the line-length bus.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
term_ready  in  1  terminal has a line available (terminal out_newASCII_ready).
term_len  in  LEN_W  line length, valid while term_ready=1.
term_char  in  8  current character from the terminal (0 once all characters have been read).
term_next  out  1  one-cycle pulse: character consumed, advance.
resp_ready  out  1  response character valid (terminal in_newASCII_ready).
resp_char  out  8  response character; 0 terminates the line.
resp_next  in  1  terminal took resp_char (terminal lineIn_nextASCII), one-cycle pulse.
solved  out  1  one-cycle pulse: command finished (terminal in_solved).
solved_ack  in  1  terminal acknowledge of solved (terminal out_solved).
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: term_next=0, resp_ready=0, resp_char=0, solved=0, busy=0, state=IDLE, rd_cnt=0, wr_cnt=0. Buffer contents are don't-care after reset.
- Reset mid-operation: abandon the current line immediately. The block does not emit solved for the abandoned line.
- IDLE:
  - When term_ready=1, latch eff_len = min(term_len, BUFFER_LEN), clear rd_cnt, go to RECV.
  - If eff_len=0, go straight to DRAIN.
- RECV:
  - One character per cycle: buf[rd_cnt] <= term_char, term_next=1, rd_cnt++.
  - Last write happens when rd_cnt = eff_len-1, then go to DRAIN.
  - term_next is never asserted while rd_cnt >= eff_len.
- DRAIN:
  - Wait for term_ready=0, then go to PARSE.
  - term_next held 0.
- PARSE (1 cycle): classify the buffer. Matching is case-sensitive with no leading-space trimming.
  - len=0 → EMPTY: go to SOLVE with no response line.
  - buf[0..3]="echo" and (len=4 or buf[4]=0x20) → ECHO. Source = buf[5..len-1]; the source is empty when len<=5.
  - Otherwise → UNKNOWN. Source = fixed ROM string "command not found" (17 chars).
- SEND:
  - Present resp_ready=1 and resp_char = source[wr_cnt], or 0 when wr_cnt = source length.
  - Hold resp_char stable until resp_next=1 is seen. Any terminal stall (e.g. its line-scroll cycle) is absorbed by this hold.
  - On resp_next: if the presented char was 0, drop resp_ready and go to SOLVE; else wr_cnt++.
  - resp_next while resp_ready=0 is ignored.
- SOLVE: solved=1 for exactly one cycle, then go to WAIT_ACK.
- WAIT_ACK:
  - On solved_ack=1, go to IDLE.
  - solved_ack seen in the same cycle as the solved pulse is also accepted.
- term_ready asserted in any non-IDLE state is ignored until IDLE.
- Only one of term_next / resp_ready activity occurs per state; they never overlap.
- Width rules:
  - rd_cnt and wr_cnt are clog2(BUFFER_LEN)+1 bits.
  - term_len is compared at full LEN_W width before clamping.

Optional Feature:
Macro BASH_HELP_CMD_EN.
- Defined: PARSE also recognises buf[0..3]="help" with len=4 exactly. Response is ROM string "cmds: echo help" (15 chars), streamed as in SEND.
- Undefined: "help" classifies as UNKNOWN and returns "command not found"; the help ROM and comparator are absent.

Test Plan:
- Empty line: term_ready with term_len=0 → no term_next pulses, no resp_ready, solved one cycle → after solved_ack, busy=0.
- "echo hi" (len 7) → exactly 7 term_next pulses; response bytes 0x68,0x69,0x00, each held until resp_next; then one solved pulse.
- "ls" (len 2) → response "command not found" followed by 0x00 (18 handshakes) → solved.
- resp_next delayed by 5 cycles on every byte → resp_char stable across each stall; no duplicated or skipped bytes.
- term_len=200 with a 200-char line starting "echo " → only 128 term_next pulses; echoed bytes are buf[5..127] (123 chars) + 0x00.
- rst asserted mid-SEND after 3 bytes → next cycle resp_ready=0, no solved pulse; a new "echo a" line then processes normally. With BASH_HELP_CMD_EN defined, "help" → "cmds: echo help" + 0x00.
